// File: rtl/mel_frame_sequencer_if.sv
// Stream bundle between the mel frame sequencer and its neighbours: the
//   upstream power-spectrum bin stream (ps_*) and the downstream energy
//   stream (out_*), both valid/ready.
// Ports (signals): ps_valid/ps_ready/ps_data/ps_last - spectrum bins in;
//   out_valid/out_ready/out_data/out_idx/out_last - mel energies out.
// master: spectrum source + energy sink side. slave: the sequencer.
interface mel_frame_sequencer_if #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int NF_LOG2      = 6
);
  logic                    ps_valid;
  logic                    ps_ready;
  logic [INPUT_WIDTH-1:0]  ps_data;
  logic                    ps_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUTPUT_WIDTH-1:0] out_data;
  logic [NF_LOG2-1:0]      out_idx;
  logic                    out_last;

  modport master (
    output ps_valid, ps_data, ps_last, out_ready,
    input  ps_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  ps_valid, ps_data, ps_last, out_ready,
    output ps_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/mel_frame_sequencer.sv
// Frame controller for the mel filterbank: load NRFFT bins, start mel, capture
//   NUM_FILTERS energies, stream them out. mel_start one cycle after last bin.
// Backpressure: ps_ready only in LOAD; DRAIN holds data/index while out_ready=0.
// Ports: clk/rst (sync, active-high); strm_io = upstream bin + downstream
//   energy streams; mel_* = spectrum-buffer writes, start pulse and energy
//   return from the mel block; frame_err_o one-cycle error pulse; busy_o high
//   outside LOAD; frame_cnt_o counts completed frames (wraps).
module mel_frame_sequencer #(
  parameter int NUM_FILTERS  = 40,
  parameter int NRFFT        = 257,
  parameter int NRFFT_LOG2   = $clog2(NRFFT),
  parameter int NF_LOG2      = $clog2(NUM_FILTERS),
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int TIMEOUT      = 16384,
  parameter int FCNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mel_frame_sequencer_if.slave    strm_io,
  output logic                    mel_in_valid_o,
  output logic [NRFFT_LOG2-1:0]   mel_ptr_o,
  output logic [INPUT_WIDTH-1:0]  mel_data_o,
  output logic                    mel_start_o,
  input  logic                    mel_valid_i,
  input  logic [NF_LOG2-1:0]      mel_prt_i,
  input  logic [OUTPUT_WIDTH-1:0] mel_value_i,
  input  logic                    mel_done_i,
  output logic                    frame_err_o,
  output logic                    busy_o,
  output logic [FCNT_WIDTH-1:0]   frame_cnt_o
);

  // Capture counter is one bit wider than the filter index so that a count
  // of exactly NUM_FILTERS is representable even for power-of-two sizes.
  localparam int CAP_W = NF_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [NRFFT_LOG2-1:0] LAST_BIN = NRFFT_LOG2'(NRFFT - 1);
  localparam logic [CAP_W-1:0]      NF_CAP   = CAP_W'(NUM_FILTERS);
  localparam logic [NF_LOG2-1:0]    LAST_IDX = NF_LOG2'(NUM_FILTERS - 1);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

  state_t                  state_q;
  logic [NRFFT_LOG2-1:0]   bin_cnt_q;
  logic [CAP_W-1:0]        cap_q;
  logic [CAP_W-1:0]        cap_d;
  logic [WD_W-1:0]         wd_q;
  logic [NF_LOG2-1:0]      rd_idx_q;
  logic [FCNT_WIDTH-1:0]   frame_cnt_q;
  logic                    ps_ready_q;
  logic                    mel_start_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    frame_err_q;
  logic                    done_prev_q;
  logic [OUTPUT_WIDTH-1:0] ebuf_q [NUM_FILTERS];

  logic ps_fire;
  logic out_fire;
  logic mel_capture;
  logic done_rise;

  // ps_ready_q is only ever high in LOAD, so a fire implies LOAD.
  assign ps_fire     = ps_ready_q & strm_io.ps_valid;
  assign out_fire    = out_valid_q & strm_io.out_ready;
  assign mel_capture = (state_q == RUN) & mel_valid_i &
                       ({1'b0, mel_prt_i} < NF_CAP);
  // A done level held across several cycles must only be acted on once.
  assign done_rise   = mel_done_i & ~done_prev_q;

  // Capture count including a capture in the current cycle; saturates so
  // duplicate energies can never wrap back to a "complete" count.
  always_comb begin
    cap_d = cap_q;
    if (mel_capture && (cap_q != '1)) begin
      cap_d = cap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      bin_cnt_q   <= '0;
      cap_q       <= '0;
      wd_q        <= '0;
      rd_idx_q    <= '0;
      frame_cnt_q <= '0;
      ps_ready_q  <= 1'b0;
      mel_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= mel_done_i;
      frame_err_q <= 1'b0;
      mel_start_q <= 1'b0;
      case (state_q)
        LOAD: begin
          ps_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (ps_fire) begin
            if (bin_cnt_q == LAST_BIN) begin
              // Full-length frame: a missing last flag is reported but the
              // frame is still processed.
              bin_cnt_q   <= '0;
              state_q     <= START;
              ps_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
              mel_start_q <= 1'b1;
              frame_err_q <= ~strm_io.ps_last;
            end else if (strm_io.ps_last) begin
              // Short frame: discard it and wait for a fresh one.
              bin_cnt_q   <= '0;
              frame_err_q <= 1'b1;
            end else begin
              bin_cnt_q <= bin_cnt_q + 1'b1;
            end
          end
        end
        START: begin
          cap_q   <= '0;
          wd_q    <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cap_q <= cap_d;
          wd_q  <= wd_q + 1'b1;
          if (done_rise) begin
            if (cap_d == NF_CAP) begin
              state_q     <= DRAIN;
              out_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= LOAD;
              ps_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else if (wd_q == WD_LAST) begin
            frame_err_q <= 1'b1;
            state_q     <= LOAD;
            ps_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_idx_q == LAST_IDX) begin
              // Ready goes high with the state change so the next frame's
              // first bin can be taken in the following cycle.
              rd_idx_q    <= '0;
              out_valid_q <= 1'b0;
              state_q     <= LOAD;
              ps_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Energy buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (mel_capture) begin
      ebuf_q[mel_prt_i] <= mel_value_i;
    end
  end

  assign strm_io.ps_ready  = ps_ready_q;
  assign mel_in_valid_o    = ps_fire;
  assign mel_ptr_o         = bin_cnt_q;
  assign mel_data_o        = strm_io.ps_data;
  assign mel_start_o       = mel_start_q;
  assign strm_io.out_valid = out_valid_q;
  assign strm_io.out_data  = ebuf_q[rd_idx_q];
  assign strm_io.out_idx   = rd_idx_q;
  assign strm_io.out_last  = out_valid_q & (rd_idx_q == LAST_IDX);
  assign frame_err_o       = frame_err_q;
  assign busy_o            = busy_q;
  assign frame_cnt_o       = frame_cnt_q;

endmodule

// File: tb/tb_mel_frame_sequencer.sv
// Self-checking bench for mel_frame_sequencer: a table of whole-frame
//   scenarios plus hand-written timeout and reset-in-DRAIN sequences.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mel_frame_sequencer;

  localparam logic [31:0] DBASE = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        mel_in_valid_o;
  logic [8:0]  mel_ptr_o;
  logic [31:0] mel_data_o;
  logic        mel_start_o;
  logic        mel_valid_i;
  logic [5:0]  mel_prt_i;
  logic [7:0]  mel_value_i;
  logic        mel_done_i;
  logic        frame_err_o;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  mel_frame_sequencer_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8), .NF_LOG2(6)) bus ();

  mel_frame_sequencer #(
    .NUM_FILTERS(40), .NRFFT(257), .INPUT_WIDTH(32), .OUTPUT_WIDTH(8),
    .TIMEOUT(64), .FCNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .strm_io       (bus),
    .mel_in_valid_o(mel_in_valid_o),
    .mel_ptr_o     (mel_ptr_o),
    .mel_data_o    (mel_data_o),
    .mel_start_o   (mel_start_o),
    .mel_valid_i   (mel_valid_i),
    .mel_prt_i     (mel_prt_i),
    .mel_value_i   (mel_value_i),
    .mel_done_i    (mel_done_i),
    .frame_err_o   (frame_err_o),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    nbeats;
    int    last_at;
    int    n_en;
    bit    bogus;
    bit    done_last;
    bit    toggle;
    bit    exp_start;
    int    exp_err;
    int    exp_hs;
    int    exp_fcnt;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int err_seen;
  int start_seen;

  function automatic vec_t mkv(string nm, int nbeats, int last_at, int n_en,
                               bit bogus, bit done_last, bit toggle,
                               bit exp_start, int exp_err, int exp_hs, int exp_fcnt);
    vec_t v;
    v.nm = nm; v.nbeats = nbeats; v.last_at = last_at; v.n_en = n_en;
    v.bogus = bogus; v.done_last = done_last; v.toggle = toggle;
    v.exp_start = exp_start; v.exp_err = exp_err; v.exp_hs = exp_hs;
    v.exp_fcnt = exp_fcnt;
    return v;
  endfunction

  function automatic logic [7:0] ev(int vi, int k);
    return 8'(k + 1 + 2 * vi);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic observe();
    if (frame_err_o === 1'b1) err_seen++;
    if (mel_start_o === 1'b1) start_seen++;
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk); #1;
  endtask

  // Offers nbeats bins; returns beats accepted, bad mel writes and the
  // mel_start level in the cycle right after the final accepted beat.
  task automatic load_frame(input int nbeats, input int last_at,
                            output int acc, output int bad, output logic st);
    int guard;
    acc = 0; bad = 0; guard = 0;
    while (acc < nbeats && guard < nbeats + 50) begin
      bus.ps_valid = 1'b1;
      bus.ps_data  = DBASE + 32'(acc);
      bus.ps_last  = (acc == last_at);
      @(negedge clk);
      guard++;
      observe();
      if (bus.ps_ready === 1'b1) begin
        if (mel_in_valid_o !== 1'b1 || mel_ptr_o !== 9'(acc) ||
            mel_data_o !== DBASE + 32'(acc)) bad++;
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.ps_valid = 1'b0;
    bus.ps_last  = 1'b0;
    @(negedge clk);
    st = mel_start_o;
    observe();
    @(posedge clk); #1;
  endtask

  // Mel block model: optional out-of-range energy, n energies k+1+2*vi at
  // index k, then done held high for two cycles in total.
  task automatic feed_mel(input int n, input int vi, input bit bogus, input bit done_last);
    bus.out_ready = 1'b0;
    if (bogus) begin
      mel_valid_i = 1'b1; mel_prt_i = 6'd45; mel_value_i = 8'hEE;
      cyc();
    end
    for (int k = 0; k < n; k++) begin
      mel_valid_i = 1'b1;
      mel_prt_i   = 6'(k);
      mel_value_i = ev(vi, k);
      mel_done_i  = done_last && (k == n - 1);
      cyc();
    end
    mel_valid_i = 1'b0;
    mel_done_i  = 1'b1;
    cyc();
    if (!done_last) cyc();
    mel_done_i = 1'b0;
  endtask

  // Consumes energies until busy drops (or stop_idx is on the bus).
  task automatic drain(input int vi, input bit toggle, input int stop_idx,
                       output int hs, output int bad, output int sbad, output logic rdy_end);
    logic [7:0] pd;
    logic [5:0] pi;
    bit         pstall;
    hs = 0; bad = 0; sbad = 0; pd = '0; pi = '0; pstall = 1'b0; rdy_end = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.out_ready = toggle ? (c[0] == 1'b0) : 1'b1;
      @(negedge clk);
      observe();
      if (busy_o !== 1'b1) begin
        rdy_end = bus.ps_ready;
        break;
      end
      if (stop_idx >= 0 && bus.out_valid === 1'b1 && bus.out_idx == 6'(stop_idx)) break;
      if (bus.out_valid === 1'b1) begin
        if (pstall && (bus.out_data !== pd || bus.out_idx !== pi)) sbad++;
        if (bus.out_idx !== 6'(hs) || bus.out_data !== ev(vi, hs) ||
            bus.out_last !== (hs == 39)) bad++;
        if (bus.out_ready) hs++;
        pstall = !bus.out_ready;
        pd = bus.out_data;
        pi = bus.out_idx;
      end else begin
        pstall = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    int   acc, bad, hs, dbad, sbad;
    logic st, rdy;
    err_seen = 0; start_seen = 0;
    load_frame(v.nbeats, v.last_at, acc, bad, st);
    chk({v.nm, "_beats"}, acc, v.nbeats);
    chk({v.nm, "_mel_wr"}, bad, 0);
    chk({v.nm, "_start_lat"}, st, v.exp_start);
    if (st === 1'b1) feed_mel(v.n_en, vi, v.bogus, v.done_last);
    drain(vi, v.toggle, -1, hs, dbad, sbad, rdy);
    chk({v.nm, "_handshakes"}, hs, v.exp_hs);
    chk({v.nm, "_out_data"}, dbad, 0);
    chk({v.nm, "_stall_stable"}, sbad, 0);
    chk({v.nm, "_err_pulses"}, err_seen, v.exp_err);
    chk({v.nm, "_start_pulses"}, start_seen, v.exp_start);
    chk({v.nm, "_frame_cnt"}, frame_cnt_o, v.exp_fcnt);
    chk({v.nm, "_ready_after"}, rdy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=stuck expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[7];
    int   acc, bad, hs, dbad, sbad, n;
    logic st, rdy;

    vecs[0] = mkv("full",      257, 256, 40, 0, 0, 0, 1, 0, 40, 1);
    vecs[1] = mkv("stall",     257, 256, 40, 0, 1, 1, 1, 0, 40, 2);
    vecs[2] = mkv("short",     101, 100,  0, 0, 0, 0, 0, 1,  0, 2);
    vecs[3] = mkv("aftshort",  257, 256, 40, 0, 0, 0, 1, 0, 40, 3);
    vecs[4] = mkv("missing",   257, 256, 39, 0, 0, 0, 1, 1,  0, 3);
    vecs[5] = mkv("nolast",    257,  -1, 40, 0, 0, 0, 1, 1, 40, 4);
    vecs[6] = mkv("badidx",    257, 256, 40, 1, 0, 0, 1, 0, 40, 5);

    rst = 1'b1;
    bus.ps_valid = 1'b0; bus.ps_data = '0; bus.ps_last = 1'b0; bus.out_ready = 1'b0;
    mel_valid_i = 1'b0; mel_prt_i = '0; mel_value_i = '0; mel_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ps_ready", bus.ps_ready, 0);
    chk("rst_mel_in_valid", mel_in_valid_o, 0);
    chk("rst_mel_start", mel_start_o, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frame_err", frame_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_ps_ready", bus.ps_ready, 1);
    chk("rel_busy", busy_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

    // Watchdog: no energies, no done.
    err_seen = 0; start_seen = 0;
    load_frame(257, 256, acc, bad, st);
    chk("to_start", st, 1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_err_o === 1'b1) begin
        n = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk("to_err_cycle", n, 65);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_ready_next", bus.ps_ready, 1);
    chk("to_err_single", frame_err_o, 0);
    chk("to_frame_cnt", frame_cnt_o, 5);
    @(posedge clk); #1;

    // Reset while index 20 is on the output.
    err_seen = 0; start_seen = 0;
    load_frame(257, 256, acc, bad, st);
    chk("rm_start", st, 1);
    feed_mel(40, 7, 1'b0, 1'b0);
    drain(7, 1'b0, 20, hs, dbad, sbad, rdy);
    chk("rm_hs_before", hs, 20);
    chk("rm_data_before", dbad, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm_out_valid", bus.out_valid, 0);
    chk("rm_out_last", bus.out_last, 0);
    chk("rm_ps_ready", bus.ps_ready, 0);
    chk("rm_busy", busy_o, 0);
    chk("rm_frame_cnt", frame_cnt_o, 0);
    chk("rm_frame_err", frame_err_o, 0);
    chk("rm_mel_start", mel_start_o, 0);
    chk("rm_mel_in_valid", mel_in_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(mkv("postrst", 257, 256, 40, 0, 0, 0, 1, 0, 40, 1), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
